mmio_uart_rx: RTL and testbench

Memory-mapped UART receiver for the Nexys4 DDR CPU top. It deserialises 8N1 frames from `uart_rxd` into a small receive FIFO, and the CPU drains that FIFO with word loads on the MMIO bus. It is the receive-side counterpart of the TX character port at 0xf0000100 and sits beside it on the same `mmio_oe`/`mmio_we`/address decode.

---
 rtl/mmio_uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_mmio_uart_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_rx.sv
// MMIO UART receiver: 8N1 deserialiser feeding a small FIFO that the CPU drains via word loads.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a live parity-error flag.
module mmio_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter logic [31:0] ADDR_DATA    = 32'hf0000104,
    parameter logic [31:0] ADDR_STAT    = 32'hf0000108
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        mmio_oe,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_addr,
    output logic [31:0] mmio_rdata,
    output logic        mmio_rsel
);
    localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // synchroniser plus one extra stage for falling-edge detection
    logic rxd_s1, rxd_s2, rxd_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    logic fall;
    assign fall = rxd_q & ~rxd_s2;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_tick, half_tick;
    logic          par_ok;

    assign bit_tick  = (timer == TW'(CLKS_PER_BIT - 1));
    assign half_tick = (timer == TW'(CLKS_PER_BIT / 2 - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    if (half_tick) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        state   <= rxd_s2 ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        timer   <= '0;
                        shreg   <= {rxd_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= PARITY;
`else
                        if (bit_cnt == 3'd7) state <= STOP;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        timer <= '0;
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // leaving mid-stop-bit lets the next start edge be caught with no idle gap
                    if (bit_tick) state <= IDLE;
                    else          timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_ok_q;
    always_ff @(posedge clk) begin
        if (!rst)                                par_ok_q <= 1'b1;
        else if (state == PARITY && bit_tick)    par_ok_q <= (rxd_s2 == ^shreg);
    end
    assign par_ok = par_ok_q;
`else
    assign par_ok = 1'b1;
`endif

    logic stop_hit, push_req, ferr_set, perr_set;
    assign stop_hit = (state == STOP) && bit_tick;
    assign push_req = stop_hit && rxd_s2 && par_ok;
    assign ferr_set = stop_hit && !rxd_s2;
    assign perr_set = stop_hit && !par_ok;

    // MMIO decode
    logic rd_data, rd_stat, wr_stat;
    assign rd_data = mmio_oe && (mmio_we == 4'b0000) && (mmio_addr == ADDR_DATA);
    assign rd_stat = mmio_oe && (mmio_we == 4'b0000) && (mmio_addr == ADDR_STAT);
    assign wr_stat = mmio_oe && mmio_we[0] && (mmio_addr == ADDR_STAT);

    // FIFO
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         count;
    logic                  empty, full, pop, push, ovr_set;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_data && !empty;
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // sticky flags: a set in the same cycle as a clear wins
    logic ovr, ferr, perr;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            perr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~wr_stat);
            ferr <= ferr_set | (ferr & ~wr_stat);
`ifdef UART_RX_PARITY_EN
            perr <= perr_set | (perr & ~wr_stat);
`else
            perr <= 1'b0;
`endif
        end
    end

    logic [31:0] stat_word;
    assign stat_word = {16'b0, 8'(count), 5'b0, perr, ferr, ovr};

    always_ff @(posedge clk) begin
        if (!rst) begin
            mmio_rdata <= '0;
            mmio_rsel  <= 1'b0;
        end else begin
            mmio_rsel <= rd_data | rd_stat;
            if (rd_data)      mmio_rdata <= empty ? 32'h0 : {23'b0, 1'b1, mem[rptr]};
            else if (rd_stat) mmio_rdata <= stat_word;
            else              mmio_rdata <= 32'h0;
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_ok;
    assign unused_ok = perr_set;
`endif

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Directed bench for mmio_uart_rx with CLKS_PER_BIT=16, DEPTH_LOG2=2.
module tb_mmio_uart_rx;
    localparam int C = 16;
    localparam logic [31:0] AD = 32'hf0000104;
    localparam logic [31:0] AS = 32'hf0000108;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        mmio_oe = 1'b0;
    logic [3:0]  mmio_we = 4'b0;
    logic [31:0] mmio_addr = 32'h0;
    logic [31:0] mmio_rdata;
    logic        mmio_rsel;

    int checks = 0;
    int errors = 0;

    mmio_uart_rx #(.CLKS_PER_BIT(C), .DEPTH_LOG2(2), .ADDR_DATA(AD), .ADDR_STAT(AS)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .mmio_oe(mmio_oe), .mmio_we(mmio_we),
        .mmio_addr(mmio_addr), .mmio_rdata(mmio_rdata), .mmio_rsel(mmio_rsel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`else
        if (par_b) begin end
`endif
        send_bit(stop_b);
        rxd = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] d);
        send(d, 1'b1, ^d);
    endtask

    // issue a read, sample the registered response one cycle later, then confirm it drops
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_sel);
        @(negedge clk);
        mmio_oe = 1'b1; mmio_we = 4'b0; mmio_addr = a;
        @(negedge clk);
        mmio_oe = 1'b0;
        chk(tag, mmio_rdata, exp);
        chk({tag, "_rsel"}, {31'b0, mmio_rsel}, {31'b0, exp_sel});
        @(negedge clk);
        chk({tag, "_hold"}, {31'b0, mmio_rsel}, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] we);
        @(negedge clk);
        mmio_oe = 1'b1; mmio_we = we; mmio_addr = a;
        @(negedge clk);
        mmio_oe = 1'b0; mmio_we = 4'b0;
        chk("wr_rsel", {31'b0, mmio_rsel}, 32'h0);
        chk("wr_rdata", mmio_rdata, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", mmio_rdata, 32'h0);
        chk("rst_rsel", {31'b0, mmio_rsel}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rd("stat_init", AS, 32'h0, 1'b1);

        // single byte
        send_ok(8'h41);
        rd("rd_41", AD, 32'h141, 1'b1);
        rd("rd_empty", AD, 32'h0, 1'b1);
        rd("stat_after_41", AS, 32'h0, 1'b1);
        rd("other_addr", 32'hf0000100, 32'h0, 1'b0);

        // back-to-back frames, no idle gap
        send_ok(8'h55);
        send_ok(8'hAA);
        send_ok(8'h00);
        send_ok(8'hFF);
        rd("stat_cnt4", AS, 32'h400, 1'b1);
        wr(AD, 4'hF);
        rd("stat_after_dwr", AS, 32'h400, 1'b1);
        rd("rd_55", AD, 32'h155, 1'b1);
        rd("stat_cnt3", AS, 32'h300, 1'b1);
        rd("rd_AA", AD, 32'h1AA, 1'b1);
        rd("rd_00", AD, 32'h100, 1'b1);
        rd("rd_FF", AD, 32'h1FF, 1'b1);
        rd("stat_drained", AS, 32'h0, 1'b1);

        // overrun: five bytes into four slots
        send_ok(8'h11);
        send_ok(8'h22);
        send_ok(8'h33);
        send_ok(8'h44);
        send_ok(8'h55);
        rd("stat_ovr", AS, 32'h401, 1'b1);
        rd("ovr_11", AD, 32'h111, 1'b1);
        rd("ovr_22", AD, 32'h122, 1'b1);
        rd("ovr_33", AD, 32'h133, 1'b1);
        rd("ovr_44", AD, 32'h144, 1'b1);
        rd("ovr_empty", AD, 32'h0, 1'b1);
        rd("stat_ovr_only", AS, 32'h001, 1'b1);
        wr(AS, 4'h1);
        rd("stat_cleared", AS, 32'h0, 1'b1);

        // short glitch is rejected as a false start
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * C) @(negedge clk);
        rd("glitch_stat", AS, 32'h0, 1'b1);
        rd("glitch_data", AD, 32'h0, 1'b1);

        // framing error
        send(8'h3C, 1'b0, ^8'h3C);
        repeat (C) @(negedge clk);
        rd("ferr_stat", AS, 32'h002, 1'b1);
        wr(AS, 4'h1);
        rd("ferr_clear", AS, 32'h0, 1'b1);

        // reset mid-frame: held low until the abandoned frame's line activity ends
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h7E >> i));
        rxd = 1'b1;
        repeat (C / 2) @(negedge clk);
        rst = 1'b0;
        mmio_oe = 1'b1; mmio_addr = AS;
        @(negedge clk);
        chk("rst_mid_rdata", mmio_rdata, 32'h0);
        chk("rst_mid_rsel", {31'b0, mmio_rsel}, 32'h0);
        mmio_oe = 1'b0;
        repeat (C / 2 - 1) @(negedge clk);
        for (int i = 5; i < 8; i++) send_bit(1'(8'h7E >> i));
`ifdef UART_RX_PARITY_EN
        send_bit(^8'h7E);
`endif
        send_bit(1'b1);
        chk("rst_hold_rdata", mmio_rdata, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_ok(8'h12);
        rd("rd_12", AD, 32'h112, 1'b1);
        rd("rd_12_empty", AD, 32'h0, 1'b1);
        rd("stat_after_rst", AS, 32'h0, 1'b1);

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b0);
        rd("par_ok", AD, 32'h103, 1'b1);
        send(8'h03, 1'b1, 1'b1);
        rd("par_bad_stat", AS, 32'h004, 1'b1);
        rd("par_bad_data", AD, 32'h0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
